// File: rtl/adc_framer_pkg.sv
// adc_framer_pkg: shared sample width, FIFO entry field offsets, FSM states and popcount
package adc_framer_pkg;
  localparam int SAMPLE_WIDTH = 16;
  localparam int MAX_CHANNELS = 32;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int idx_lsb(int width);
    return 2 * width;
  endfunction
  function automatic int last_lsb(int width, int uw);
    return 2 * width + uw;
  endfunction
  function automatic int popcount(logic [MAX_CHANNELS-1:0] v);
    int n = 0;
    for (int i = 0; i < MAX_CHANNELS; i++) n += int'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/adc_framer_sample_fifo.sv
// sample_fifo: first-word-fall-through FIFO with a registered output stage; count covers both
module sample_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] mcnt;
  logic pop, load;
  assign pop = rd_valid & rd_ready;
  assign load = (mcnt != '0) && (!rd_valid || pop);
  assign count = mcnt + (AW+1)'(rd_valid);
  always_ff @(posedge clk) if (wr_en) mem[wp] <= wr_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      mcnt <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (load) rp <= rp + 1'b1;
      mcnt <= mcnt + (AW+1)'(wr_en) - (AW+1)'(load);
      rd_valid <= load | (rd_valid & !pop);
      if (load) rd_data <= mem[rp];
    end
  end
endmodule

// File: rtl/adc_framer.sv
// adc_framer: captures masked multi-channel ADC vectors, serialises them into a FIFO and
// streams them out tagged with channel index and frame boundary, counting dropped vectors.
module adc_framer
  import adc_framer_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH = 16,
  parameter int FRAME_LEN = 64,
  localparam int UW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [CHANNELS-1:0]         chan_mask,
  input  logic                        adc_valid,
  input  logic [CHANNELS*2*WIDTH-1:0] adc_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [2*WIDTH-1:0]          m_data,
  output logic [UW-1:0]               m_user,
  output logic                        m_last,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  output logic                        irq
);
  localparam int EW = 2 * WIDTH + UW + 1;
  localparam int IDX = idx_lsb(WIDTH);
  localparam int LST = last_lsb(WIDTH, UW);
  localparam int FCW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam int CW = (DEPTH > 1 ? $clog2(DEPTH) : 1) + 1;
  state_t state, state_n;
  logic [CHANNELS*2*WIDTH-1:0] data_q;
  logic [CHANNELS-1:0] rem_q, rem_n;
  logic last_q, req, fits, accept, drop, final_wr, wr_en;
  logic [FCW-1:0] frame_cnt;
  logic [CW-1:0] fifo_count;
  logic [UW-1:0] sel;
  logic [EW-1:0] wr_entry, rd_entry;
  assign req = adc_valid & enable & (chan_mask != '0);
  assign fits = (DEPTH - int'(fifo_count)) >= popcount(MAX_CHANNELS'(chan_mask));
  assign accept = req && (state == IDLE) && fits;
  assign drop = req && !accept;
  assign rem_n = rem_q & (rem_q - CHANNELS'(1));
  assign final_wr = rem_n == '0;
  assign wr_en = state == SHIFT;
  assign wr_entry = {last_q & final_wr, sel, data_q[int'(sel)*2*WIDTH +: 2*WIDTH]};
  assign state_n = (state == IDLE) ? (accept ? SHIFT : IDLE) : (final_wr ? IDLE : SHIFT);
  always_comb begin
    sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (rem_q[i]) sel = UW'(i);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      data_q <= '0;
      rem_q <= '0;
      last_q <= 1'b0;
      frame_cnt <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
      irq <= 1'b0;
    end else begin
      state <= state_n;
      irq <= m_valid & m_ready & m_last;
      if (accept) begin
        data_q <= adc_data;
        rem_q <= chan_mask;
        last_q <= frame_cnt == FCW'(FRAME_LEN - 1);
        frame_cnt <= (frame_cnt == FCW'(FRAME_LEN - 1)) ? '0 : frame_cnt + 1'b1;
      end else if (!enable && state == IDLE) begin
        frame_cnt <= '0;
      end
      if (wr_en) rem_q <= rem_n;
      if (drop) begin
        overflow <= 1'b1;
        drop_count <= drop_count + 16'(drop_count != 16'hFFFF);
      end
    end
  end
  sample_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_data(wr_entry),
    .rd_valid(m_valid),
    .rd_ready(m_ready),
    .rd_data(rd_entry),
    .count(fifo_count)
  );
  assign m_data = rd_entry[2*WIDTH-1:0];
  assign m_user = rd_entry[IDX +: UW];
  assign m_last = rd_entry[LST];
endmodule

// File: tb/tb_adc_framer.sv
// tb_adc_framer: directed checks of adc_framer with CHANNELS=2, DEPTH=16, FRAME_LEN=2
module tb_adc_framer;
  logic clk = 0, reset = 1, enable = 0, adc_valid = 0, m_ready = 0;
  logic [1:0] chan_mask = 2'b11;
  logic [63:0] adc_data = 64'h0003_0004_0001_0002;
  logic m_valid, m_last, overflow, irq;
  logic [31:0] m_data;
  logic [0:0] m_user;
  logic [15:0] drop_count;
  logic [33:0] beats[$];
  int irqs = 0, passed = 0, total = 0;
  localparam logic [31:0] CH0 = 32'h0001_0002, CH1 = 32'h0003_0004;

  adc_framer #(.CHANNELS(2), .WIDTH(16), .DEPTH(16), .FRAME_LEN(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .adc_valid(adc_valid), .adc_data(adc_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_user(m_user), .m_last(m_last), .overflow(overflow),
    .drop_count(drop_count), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_valid && m_ready) beats.push_back({m_last, m_user, m_data});
    if (irq) irqs++;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    adc_valid = 1;
    tick(1);
    adc_valid = 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [33:0] beat_at(int i);
    return (i < beats.size()) ? beats[i] : '1;
  endfunction

  function automatic logic [33:0] pair_beat(int i, logic last);
    return {last, i[0], i[0] ? CH1 : CH0};
  endfunction

  initial begin
    tick(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_user", m_user, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_irq", irq, 0);
    reset = 0;
    enable = 1;
    m_ready = 1;
    tick(2);
    // frame 0: two vectors with cycle-accurate latency and irq checks
    strobe();
    chk("t1_lat_t0", m_valid, 0);
    tick(1);
    chk("t1_lat_t1", m_valid, 0);
    tick(1);
    chk("t1_lat_t2_valid", m_valid, 1);
    chk("t1_b0", {m_last, m_user, m_data}, {1'b0, 1'b0, CH0});
    tick(1);
    chk("t1_b1", {m_valid, m_last, m_user, m_data}, {1'b1, 1'b0, 1'b1, CH1});
    strobe();
    chk("t1_gap_valid", m_valid, 0);
    tick(2);
    chk("t1_b2", {m_valid, m_last, m_user, m_data}, {1'b1, 1'b0, 1'b0, CH0});
    tick(1);
    chk("t1_b3_last", {m_valid, m_last, m_user, m_data}, {1'b1, 1'b1, 1'b1, CH1});
    chk("t1_irq_before", irq, 0);
    tick(1);
    chk("t1_irq_pulse", irq, 1);
    chk("t1_valid_after", m_valid, 0);
    tick(1);
    chk("t1_irq_clear", irq, 0);
    strobe();
    tick(3);
    strobe();
    tick(6);
    chk("t1_beat_count", beats.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_beat", beat_at(i), pair_beat(i, i % 4 == 3));
    chk("t1_irq_count", irqs, 2);
    chk("t1_no_drop", drop_count, 0);
    // single channel 1: one vector every two cycles, frame counter starts at 0
    beats.delete();
    chan_mask = 2'b10;
    for (int i = 0; i < 3; i++) begin
      strobe();
      tick(1);
    end
    tick(4);
    chk("t2_beat_count", beats.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_beat", beat_at(i), {i == 1, 1'b1, CH1});
    chk("t2_no_drop", drop_count, 0);
    chk("t2_no_overflow", overflow, 0);
    // strobes every two cycles with both channels: the one on the final write is dropped
    beats.delete();
    chan_mask = 2'b11;
    for (int i = 0; i < 6; i++) begin
      strobe();
      tick(1);
    end
    tick(6);
    chk("t3_drop_count", drop_count, 3);
    chk("t3_overflow", overflow, 1);
    chk("t3_beat_count", beats.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_beat", beat_at(i), pair_beat(i, i == 1 || i == 5));
    // back-pressure: eight vectors fill sixteen entries, the ninth is dropped
    reset = 1;
    tick(1);
    reset = 0;
    m_ready = 0;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      strobe();
      tick(3);
    end
    chk("t4_drop_count", drop_count, 1);
    chk("t4_overflow", overflow, 1);
    chk("t4_head", {m_valid, m_last, m_user, m_data}, {1'b1, 1'b0, 1'b0, CH0});
    // saturation of the drop counter
    adc_valid = 1;
    tick(70000);
    adc_valid = 0;
    chk("t5_saturate", drop_count, 16'hFFFF);
    chk("t5_head_stable", {m_valid, m_user, m_data}, {1'b1, 1'b0, CH0});
    tick(1);
    chk("t5_saturate_hold", drop_count, 16'hFFFF);
    // reset during SHIFT with five entries queued, frame counter left at vector 1
    m_ready = 1;
    tick(20);
    chk("t6_drained", m_valid, 0);
    m_ready = 0;
    strobe();
    tick(3);
    strobe();
    tick(3);
    strobe();
    tick(1);
    reset = 1;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_drops", drop_count, 0);
    chk("t6_rst_last", m_last, 0);
    tick(1);
    reset = 0;
    beats.delete();
    irqs = 0;
    m_ready = 1;
    tick(1);
    strobe();
    tick(3);
    strobe();
    tick(6);
    chk("t6_beat_count", beats.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6_beat", beat_at(i), pair_beat(i, i == 3));
    chk("t6_irq_count", irqs, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
